mem_bus_arbiter: RTL

//  Shares one SRAM-like memory bus between the fetch port (pcF/instrF) and the

---
 rtl/mem_bus_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one SRAM-like memory bus between the instruction-fetch
//            port and the data (load/store) port of a 5-stage pipeline.
//            Only one bus transaction is outstanding at a time. The data
//            port is preferred. A starvation counter forces a fetch grant
//            after STARVE_LIMIT consecutive data grants made while a fetch
//            was waiting.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            i_flush             cancels the result of an in-flight fetch
//            i_inst_*            fetch request / address
//            o_inst_*            fetched word, completion pulse, stall
//            i_data_*            data request / wr / byte enables / addr / wdata
//            o_data_*            load word, completion pulse, stall
//            o_bus_*             registered bus request and transaction fields
//            i_bus_*             slave address/data handshakes and read data
// Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    // fetch port
    input  logic        i_inst_req,
    input  logic [31:0] i_inst_addr,
    output logic [31:0] o_inst_rdata,
    output logic        o_inst_ok,
    output logic        o_inst_stall,
    // data port
    input  logic        i_data_req,
    input  logic        i_data_wr,
    input  logic [3:0]  i_data_sel,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic [31:0] o_data_rdata,
    output logic        o_data_ok,
    output logic        o_data_stall,
    // memory bus
    output logic        o_bus_req,
    output logic        o_bus_wr,
    output logic [3:0]  o_bus_sel,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_addr_ok,
    input  logic        i_bus_data_ok,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_A_I    = 3'd1,
        S_A_D    = 3'd2,
        S_W_I    = 3'd3,
        S_W_D    = 3'd4,
        S_DONE_I = 3'd5,
        S_DONE_D = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] c_STARVE_LIMIT = CNT_W'(STARVE_LIMIT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic               r_cancel;
    logic [31:0]        r_inst_rdata;
    logic [31:0]        r_data_rdata;
    logic               r_bus_wr;
    logic [3:0]         r_bus_sel;
    logic [31:0]        r_bus_addr;
    logic [31:0]        r_bus_wdata;

    logic               w_grant_d;
    logic               w_grant_i;
    logic               w_fetch_phase;
    logic               w_cancel;

    // ------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Data wins unless a waiting fetch has been passed over
                // STARVE_LIMIT times in a row.
                if (i_data_req && ((r_starve_cnt < c_STARVE_LIMIT) || !i_inst_req)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_A_D;
                end else if (i_inst_req && !i_flush) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_A_I;
                end
            end
            S_A_I:    if (i_bus_addr_ok) w_state_nxt = S_W_I;
            S_A_D:    if (i_bus_addr_ok) w_state_nxt = S_W_D;
            S_W_I:    if (i_bus_data_ok) w_state_nxt = S_DONE_I;
            S_W_D:    if (i_bus_data_ok) w_state_nxt = S_DONE_D;
            S_DONE_I: w_state_nxt = S_IDLE;
            S_DONE_D: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Fetch cancellation: a flush seen at any point of a fetch
    // transaction discards its result; the bus cycle itself still runs
    // to completion so the slave is never left half-way.
    // ------------------------------------------------------------------
    assign w_fetch_phase = (r_state == S_A_I) || (r_state == S_W_I) || (r_state == S_DONE_I);
    assign w_cancel      = r_cancel || (i_flush && w_fetch_phase);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cancel <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_cancel <= 1'b0;
        end else if (i_flush && w_fetch_phase) begin
            r_cancel <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!i_inst_req || w_grant_i) begin
            r_starve_cnt <= '0;
        end else if (w_grant_d && (r_starve_cnt < c_STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Bus transaction registers: captured on the grant edge and held
    // until the next grant, so they are stable across A_x and W_x.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_wr    <= 1'b0;
            r_bus_sel   <= 4'h0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
        end else if (w_grant_d) begin
            r_bus_wr    <= i_data_wr;
            r_bus_sel   <= i_data_sel;
            r_bus_addr  <= i_data_addr;
            r_bus_wdata <= i_data_wdata;
        end else if (w_grant_i) begin
            r_bus_wr    <= 1'b0;
            r_bus_sel   <= 4'hF;
            r_bus_addr  <= i_inst_addr;
            r_bus_wdata <= 32'h0;
        end
    end

    // ------------------------------------------------------------------
    // Read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_rdata <= 32'h0;
        end else if ((r_state == S_W_I) && i_bus_data_ok && !w_cancel) begin
            r_inst_rdata <= i_bus_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_rdata <= 32'h0;
        end else if ((r_state == S_W_D) && i_bus_data_ok && !r_bus_wr) begin
            r_data_rdata <= i_bus_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_bus_req    = (r_state == S_A_I) || (r_state == S_A_D);
    assign o_bus_wr     = r_bus_wr;
    assign o_bus_sel    = r_bus_sel;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_wdata  = r_bus_wdata;

    assign o_inst_ok    = (r_state == S_DONE_I) && !w_cancel;
    assign o_data_ok    = (r_state == S_DONE_D);
    assign o_inst_rdata = r_inst_rdata;
    assign o_data_rdata = r_data_rdata;
    assign o_inst_stall = i_inst_req && !o_inst_ok;
    assign o_data_stall = i_data_req && !o_data_ok;

endmodule
`default_nettype wire
